// File: rtl/batcher_if.sv
// Crossbar lane bundle: per-lane data words and routing tags in, reordered words out.
interface xbar_if #(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 16,
    parameter int TAGW   = $clog2(SIZE)
);
    logic                        en;
    logic [SIZE-1:0][DWIDTH-1:0] din;
    logic [SIZE-1:0][TAGW-1:0]   shift;
    logic [SIZE-1:0][DWIDTH-1:0] dout;

    modport master (output en, din, shift, input dout);
    modport xbar   (input en, din, shift, output dout);
    modport slave  (input en, din, shift, output dout);
endinterface

// File: rtl/batcher.sv
// Pipelined Batcher odd-even merge sorter over SIZE unsigned lanes, ascending by default.
// Define BATCHER_DESCEND_EN to reverse every compare-exchange (descending output).
module batcher #(
    parameter int                SIZE          = 32,
    parameter int                DWIDTH        = 16,
    parameter int                TAGW          = $clog2(SIZE),
    parameter int                STAGES        = TAGW * (TAGW + 1) / 2,
    parameter logic [STAGES-2:0] REGISTER_MASK = '0
) (
    input logic  clk,
    input logic  n_rst,
    xbar_if.xbar bus
);

    // Stage s enumerates the (p, k) pairs of the merge network: p = 1,2,4..; k = p..1.
    function automatic int stage_p(input int s);
        int idx = 0;
        for (int pl = 0; pl < TAGW; pl++) begin
            for (int kl = pl; kl >= 0; kl--) begin
                if (idx == s) return 1 << pl;
                idx++;
            end
        end
        return 1;
    endfunction

    function automatic int stage_k(input int s);
        int idx = 0;
        for (int pl = 0; pl < TAGW; pl++) begin
            for (int kl = pl; kl >= 0; kl--) begin
                if (idx == s) return 1 << kl;
                idx++;
            end
        end
        return 1;
    endfunction

    // True when lane a is the lower lane of a comparator (a, a+k) in stage (p, k).
    function automatic bit is_lo(input int a, input int p, input int k);
        int base;
        base = k % p;
        if (a < base || a + k >= SIZE) return 1'b0;
        if (((a - base) % (2 * k)) >= k) return 1'b0;
        return (a / (2 * p)) == ((a + k) / (2 * p));
    endfunction

    function automatic bit reg_at(input int s);
        if (s >= STAGES - 1) return 1'b1;
        return REGISTER_MASK[s];
    endfunction

    function automatic logic [DWIDTH-1:0] lo_of(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
`ifdef BATCHER_DESCEND_EN
        return (a > b) ? a : b;
`else
        return (a < b) ? a : b;
`endif
    endfunction

    function automatic logic [DWIDTH-1:0] hi_of(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
`ifdef BATCHER_DESCEND_EN
        return (a > b) ? b : a;
`else
        return (a < b) ? b : a;
`endif
    endfunction

    // Routing tags play no part in ordering.
    logic unused_shift;
    assign unused_shift = ^bus.shift;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int P   = stage_p(s);
        localparam int K   = stage_k(s);
        localparam bit REG = reg_at(s);

        logic [SIZE-1:0][DWIDTH-1:0] d;
        logic [SIZE-1:0][DWIDTH-1:0] c;
        logic [SIZE-1:0][DWIDTH-1:0] q;

        if (s == 0) begin : g_first
            assign d = bus.din;
        end else begin : g_chain
            assign d = g_stg[s-1].q;
        end

        for (genvar x = 0; x < SIZE; x++) begin : g_lane
            if (is_lo(x, P, K)) begin : g_lo
                assign c[x] = lo_of(d[x], d[x+K]);
            end else if (x >= K && is_lo(x - K, P, K)) begin : g_hi
                assign c[x] = hi_of(d[x-K], d[x]);
            end else begin : g_pass
                assign c[x] = d[x];
            end
        end

        // Stage boundary: registered when masked in or when this is the final stage.
        if (REG) begin : g_reg
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    q <= '0;
                end else if (bus.en) begin
                    q <= c;
                end
            end
        end else begin : g_comb
            assign q = c;
        end
    end

    assign bus.dout = g_stg[STAGES-1].q;

endmodule

// File: tb/tb_batcher.sv
// Bench for batcher: three instances (L=1, L=3, L=STAGES) share stimulus and a sorted-history model.
module tb_batcher;
    localparam int SIZE = 32;
    localparam int DW   = 16;
    localparam int TW   = $clog2(SIZE);
    localparam int VW   = SIZE * DW;
    localparam int ND   = 3;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          en = 1'b0;
    logic [VW-1:0] din = '0;
    logic [SIZE*TW-1:0] shift_v = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int lat [ND] = '{1, 3, 15};

    logic [VW-1:0] dout_v [ND];
    logic [VW-1:0] hist [$];

    always #5 clk = ~clk;

    xbar_if #(.SIZE(SIZE), .DWIDTH(DW)) if0 ();
    xbar_if #(.SIZE(SIZE), .DWIDTH(DW)) if1 ();
    xbar_if #(.SIZE(SIZE), .DWIDTH(DW)) if2 ();

    assign if0.en = en;  assign if0.din = din;  assign if0.shift = shift_v;
    assign if1.en = en;  assign if1.din = din;  assign if1.shift = shift_v;
    assign if2.en = en;  assign if2.din = din;  assign if2.shift = shift_v;
    assign dout_v[0] = if0.dout;
    assign dout_v[1] = if1.dout;
    assign dout_v[2] = if2.dout;

    batcher #(.SIZE(SIZE), .DWIDTH(DW), .REGISTER_MASK(14'h0000))
        u_dut0 (.clk(clk), .n_rst(n_rst), .bus(if0));
    batcher #(.SIZE(SIZE), .DWIDTH(DW), .REGISTER_MASK(14'h0210))
        u_dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));
    batcher #(.SIZE(SIZE), .DWIDTH(DW), .REGISTER_MASK(14'h3FFF))
        u_dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));

    function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
        int unsigned a [SIZE];
        int unsigned t;
        logic [VW-1:0] r;
        for (int i = 0; i < SIZE; i++) a[i] = int'(v[i*DW +: DW]);
        for (int i = 0; i < SIZE - 1; i++) begin
            for (int j = 0; j < SIZE - 1 - i; j++) begin
`ifdef BATCHER_DESCEND_EN
                if (a[j] < a[j+1]) begin
`else
                if (a[j] > a[j+1]) begin
`endif
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        for (int i = 0; i < SIZE; i++) r[i*DW +: DW] = DW'(a[i]);
        return r;
    endfunction

    // Output after the most recent edge is the vector pushed l enabled edges ago.
    function automatic logic [VW-1:0] exp_out(input int l);
        if (hist.size() < l) return '0;
        return hist[hist.size() - l];
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int mode);
        logic [VW-1:0] v;
        for (int i = 0; i < SIZE; i++)
            v[i*DW +: DW] = (mode == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
        return v;
    endfunction

    function automatic logic [VW-1:0] order_fix(input logic [VW-1:0] asc);
`ifdef BATCHER_DESCEND_EN
        logic [VW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*DW +: DW] = asc[(SIZE-1-i)*DW +: DW];
        return r;
`else
        return asc;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        if (n_rst && en) hist.push_back(sort_vec(din));
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        hist.delete();
        for (int c = 0; c < 5; c++) begin
            din = rand_vec(0);
            shift_v = {SIZE{TW'($urandom)}};
            en = 1'($urandom);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== '0) begin
                    n_bad++;
                    $display("FAIL reset_hold dut%0d got %h want 0", d, dout_v[d]);
                end
            end
        end
        n_rst = 1'b1;
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            din = rand_vec(0);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== exp_out(lat[d]) || dout_v[d] !== '0) begin
                    n_bad++;
                    $display("FAIL reset_idle dut%0d got %h want 0", d, dout_v[d]);
                end
            end
        end
    endtask

    task automatic test_stream();
        en = 1'b1;
        for (int c = 0; c < 21; c++) begin
            din = rand_vec(c % 3 == 2 ? 1 : 0);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== exp_out(lat[d])) begin
                    n_bad++;
                    $display("FAIL stream c%0d dut%0d got %h want %h", c, d, dout_v[d], exp_out(lat[d]));
                end
            end
        end
    endtask

    task automatic test_patterns();
        logic [VW-1:0] pat;
        logic [VW-1:0] want;
        en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < SIZE; i++) begin
                case (p)
                    0: begin pat[i*DW +: DW] = DW'(SIZE - 1 - i); want[i*DW +: DW] = DW'(i); end
                    1: begin pat[i*DW +: DW] = DW'(i);            want[i*DW +: DW] = DW'(i); end
                    2: begin
                        pat[i*DW +: DW]  = (i < 16) ? 16'hFFFF : 16'h0000;
                        want[i*DW +: DW] = (i < 16) ? 16'h0000 : 16'hFFFF;
                    end
                    default: begin pat[i*DW +: DW] = 16'h1234; want[i*DW +: DW] = 16'h1234; end
                endcase
            end
            want = order_fix(want);
            din = pat;
            for (int c = 0; c < 16; c++) begin
                tick();
                for (int d = 0; d < ND; d++) begin
                    n_cmp++;
                    if (dout_v[d] !== exp_out(lat[d])) begin
                        n_bad++;
                        $display("FAIL pattern%0d c%0d dut%0d got %h want %h", p, c, d, dout_v[d], exp_out(lat[d]));
                    end
                end
            end
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== want) begin
                    n_bad++;
                    $display("FAIL pattern%0d_final dut%0d got %h want %h", p, d, dout_v[d], want);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [VW-1:0] frozen [ND];
        en = 1'b1;
        din = rand_vec(0); tick();
        din = rand_vec(1); tick();
        en = 1'b0;
        for (int d = 0; d < ND; d++) frozen[d] = exp_out(lat[d]);
        for (int c = 0; c < 4; c++) begin
            din = rand_vec(0);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== frozen[d]) begin
                    n_bad++;
                    $display("FAIL stall_hold c%0d dut%0d got %h want %h", c, d, dout_v[d], frozen[d]);
                end
            end
        end
        en = 1'b1;
        for (int c = 0; c < 17; c++) begin
            din = rand_vec(c == 0 ? 0 : 1);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== exp_out(lat[d])) begin
                    n_bad++;
                    $display("FAIL stall_resume c%0d dut%0d got %h want %h", c, d, dout_v[d], exp_out(lat[d]));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            din = rand_vec(0);
            tick();
        end
        #2 n_rst = 1'b0;
        hist.delete();
        #1;
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (dout_v[d] !== '0) begin
                n_bad++;
                $display("FAIL async_clear dut%0d got %h want 0", d, dout_v[d]);
            end
        end
        tick();
        tick();
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            din = rand_vec(c % 2);
            tick();
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (dout_v[d] !== exp_out(lat[d])) begin
                    n_bad++;
                    $display("FAIL refill c%0d dut%0d got %h want %h", c, d, dout_v[d], exp_out(lat[d]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_patterns();
        test_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
